// File: rtl/alu_exec_stage_pkg.sv
// Shared types and field encodings for the RV32I execute stage and its ALU.
package alu_exec_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_control_t;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SR);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU: result, signed overflow for ADD/SUB, zero flag.
module alu
  import alu_exec_stage_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  alu_control_t ctrl_i,
  output logic [N-1:0] result_o,
  output logic         overflow_o,
  output logic         zero_o
);

  localparam int SH_W = $clog2(N);

  logic [N-1:0]    sum_s;
  logic [N-1:0]    diff_s;
  logic [SH_W-1:0] sh_s;

  assign sum_s  = a_i + b_i;
  assign diff_s = a_i - b_i;
  assign sh_s   = b_i[SH_W-1:0];

  // Operation select; overflow is only meaningful for ADD and SUB.
  always_comb begin
    result_o   = {N{1'b0}};
    overflow_o = 1'b0;
    case (ctrl_i)
      ALU_ADD: begin
        result_o   = sum_s;
        overflow_o = (a_i[N-1] == b_i[N-1]) && (sum_s[N-1] != a_i[N-1]);
      end
      ALU_SUB: begin
        result_o   = diff_s;
        overflow_o = (a_i[N-1] != b_i[N-1]) && (diff_s[N-1] != a_i[N-1]);
      end
      ALU_SLL:  result_o = a_i << sh_s;
      ALU_SLT:  result_o = {{(N-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_o = {{(N-1){1'b0}}, (a_i < b_i)};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> sh_s;
      ALU_SRA:  result_o = $signed(a_i) >>> sh_s;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      default: begin
        result_o   = {N{1'b0}};
        overflow_o = 1'b0;
      end
    endcase
  end

  assign zero_o = (result_o == {N{1'b0}});

endmodule

// File: rtl/alu_exec_stage_decoder.sv
// Maps RV32I funct3/funct7 (R-type and I-type ALU) to an ALU control code.
module alu_op_decoder
  import alu_exec_stage_pkg::*;
(
  input  logic [2:0]   funct3_i,
  input  logic [6:0]   funct7_i,
  input  logic         is_imm_i,
  output alu_control_t ctrl_o,
  output logic         illegal_o,
  output logic         is_shift_o
);

  logic f7_base_s;
  logic f7_alt_s;

  assign f7_base_s  = (funct7_i == F7_BASE);
  assign f7_alt_s   = (funct7_i == F7_ALT);
  assign is_shift_o = is_shift_f3(funct3_i);

  // I-type non-shift ops carry immediate bits in funct7, so they never flag illegal.
  always_comb begin
    ctrl_o    = ALU_ADD;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_ADDSUB: begin
        ctrl_o    = (!is_imm_i && f7_alt_s) ? ALU_SUB : ALU_ADD;
        illegal_o = !is_imm_i && !(f7_base_s || f7_alt_s);
      end
      F3_SLL: begin
        ctrl_o    = ALU_SLL;
        illegal_o = !f7_base_s;
      end
      F3_SLT: begin
        ctrl_o    = ALU_SLT;
        illegal_o = !is_imm_i && !f7_base_s;
      end
      F3_SLTU: begin
        ctrl_o    = ALU_SLTU;
        illegal_o = !is_imm_i && !f7_base_s;
      end
      F3_XOR: begin
        ctrl_o    = ALU_XOR;
        illegal_o = !is_imm_i && !f7_base_s;
      end
      F3_SR: begin
        ctrl_o    = f7_alt_s ? ALU_SRA : ALU_SRL;
        illegal_o = !(f7_base_s || f7_alt_s);
      end
      F3_OR: begin
        ctrl_o    = ALU_OR;
        illegal_o = !is_imm_i && !f7_base_s;
      end
      F3_AND: begin
        ctrl_o    = ALU_AND;
        illegal_o = !is_imm_i && !f7_base_s;
      end
      default: begin
        ctrl_o    = ALU_ADD;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage execute pipeline around the ALU: S1 holds decoded op and operands,
// S2 holds the registered result for writeback, with valid/ready backpressure.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic             in_is_imm,
  input  logic [N-1:0]     in_rs1,
  input  logic [N-1:0]     in_rs2,
  input  logic [N-1:0]     in_imm,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic [4:0]       out_rd,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  alu_control_t     dec_ctrl_s;
  logic             dec_illegal_s;
  logic             dec_is_shift_s;
  logic [N-1:0]     opb_raw_s;
  logic [N-1:0]     opb_s;
  logic             s1_adv_s;
  logic             s2_adv_s;
  logic [N-1:0]     alu_result_s;
  logic             alu_ovf_s;
  logic             alu_zero_s;

  logic             s1_valid_q,   s1_valid_d;
  alu_control_t     s1_ctrl_q,    s1_ctrl_d;
  logic             s1_illegal_q, s1_illegal_d;
  logic [N-1:0]     s1_a_q,       s1_a_d;
  logic [N-1:0]     s1_b_q,       s1_b_d;
  logic [4:0]       s1_rd_q,      s1_rd_d;
  logic             s2_valid_q,   s2_valid_d;
  logic [N-1:0]     s2_result_q,  s2_result_d;
  logic [4:0]       s2_rd_q,      s2_rd_d;
  logic             s2_ovf_q,     s2_ovf_d;
  logic             s2_zero_q,    s2_zero_d;
  logic             s2_illegal_q, s2_illegal_d;
  logic [CNT_W-1:0] retired_q,    retired_d;

  alu_op_decoder u_dec (
    .funct3_i   (in_funct3),
    .funct7_i   (in_funct7),
    .is_imm_i   (in_is_imm),
    .ctrl_o     (dec_ctrl_s),
    .illegal_o  (dec_illegal_s),
    .is_shift_o (dec_is_shift_s)
  );

  alu #(.N(N)) u_alu (
    .a_i        (s1_a_q),
    .b_i        (s1_b_q),
    .ctrl_i     (s1_ctrl_q),
    .result_o   (alu_result_s),
    .overflow_o (alu_ovf_s),
    .zero_o     (alu_zero_s)
  );

  // Ready depends only on registered valids and out_ready, never on in_valid.
  assign s2_adv_s = !s2_valid_q || out_ready;
  assign s1_adv_s = !s1_valid_q || s2_adv_s;
  assign in_ready = s1_adv_s;

  assign opb_raw_s = in_is_imm ? in_imm : in_rs2;
  assign opb_s     = dec_is_shift_s ? {{(N-5){1'b0}}, opb_raw_s[4:0]} : opb_raw_s;

  always_comb begin
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_adv_s ? in_valid : s1_valid_q;
      s2_valid_d = s2_adv_s ? s1_valid_q : s2_valid_q;
    end
  end

  always_comb begin
    if (s1_adv_s && in_valid) begin
      s1_ctrl_d    = dec_ctrl_s;
      s1_illegal_d = dec_illegal_s;
      s1_a_d       = in_rs1;
      s1_b_d       = opb_s;
      s1_rd_d      = in_rd;
    end else begin
      s1_ctrl_d    = s1_ctrl_q;
      s1_illegal_d = s1_illegal_q;
      s1_a_d       = s1_a_q;
      s1_b_d       = s1_b_q;
      s1_rd_d      = s1_rd_q;
    end
  end

  // Illegal ops are squashed here: zero result, no overflow, zero flag set.
  always_comb begin
    if (s2_adv_s && s1_valid_q) begin
      s2_result_d  = s1_illegal_q ? {N{1'b0}} : alu_result_s;
      s2_rd_d      = s1_rd_q;
      s2_ovf_d     = !s1_illegal_q && alu_ovf_s &&
                     ((s1_ctrl_q == ALU_ADD) || (s1_ctrl_q == ALU_SUB));
      s2_zero_d    = s1_illegal_q || alu_zero_s;
      s2_illegal_d = s1_illegal_q;
    end else begin
      s2_result_d  = s2_result_q;
      s2_rd_d      = s2_rd_q;
      s2_ovf_d     = s2_ovf_q;
      s2_zero_d    = s2_zero_q;
      s2_illegal_d = s2_illegal_q;
    end
  end

  always_comb begin
    if (s2_valid_q && out_ready && (retired_q != CNT_MAX)) begin
      retired_d = retired_q + CNT_ONE;
    end else begin
      retired_d = retired_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s1_ctrl_q    <= ALU_ADD;
      s1_illegal_q <= 1'b0;
      s1_a_q       <= {N{1'b0}};
      s1_b_q       <= {N{1'b0}};
      s1_rd_q      <= 5'd0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= {N{1'b0}};
      s2_rd_q      <= 5'd0;
      s2_ovf_q     <= 1'b0;
      s2_zero_q    <= 1'b0;
      s2_illegal_q <= 1'b0;
      retired_q    <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_ctrl_q    <= s1_ctrl_d;
      s1_illegal_q <= s1_illegal_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_rd_q      <= s1_rd_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_rd_q      <= s2_rd_d;
      s2_ovf_q     <= s2_ovf_d;
      s2_zero_q    <= s2_zero_d;
      s2_illegal_q <= s2_illegal_d;
      retired_q    <= retired_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_result   = s2_result_q;
  assign out_rd       = s2_rd_q;
  assign out_overflow = s2_ovf_q;
  assign out_zero     = s2_zero_q;
  assign out_illegal  = s2_illegal_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized bench for alu_exec_stage: a queue-based reference model checked every
// cycle, plus directed beats with hand-computed results.
module tb_alu_exec_stage;

  logic        clk, rst, flush, in_valid, in_ready, in_is_imm;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_rs1, in_rs2, in_imm, out_result;
  logic [4:0]  in_rd, out_rd;
  logic        out_valid, out_ready, out_overflow, out_zero, out_illegal;
  logic [15:0] retired;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ovf;
    logic        zero;
    logic        ill;
    int          push;
  } exp_t;

  exp_t        q[$];
  int          edge_cnt = 0;
  int unsigned ret_m = 0;
  int          checks = 0;
  int          errors = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic [4:0]  prev_rd;

  alu_exec_stage #(.N(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_is_imm(in_is_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_overflow(out_overflow), .out_zero(out_zero),
    .out_illegal(out_illegal), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic exp_t ref_op(input logic [2:0] f3, input logic [6:0] f7, input logic is_imm,
                                  input logic [31:0] a, input logic [31:0] rs2,
                                  input logic [31:0] imm, input logic [4:0] rd);
    exp_t        e;
    logic [31:0] b;
    int          sh;
    longint      s;
    logic        legal;
    b      = is_imm ? imm : rs2;
    sh     = int'(b[4:0]);
    e.rd   = rd;
    e.ovf  = 1'b0;
    e.ill  = 1'b0;
    e.push = 0;
    e.res  = 32'd0;
    if (f3 == 3'd1)      legal = (f7 == 7'h00);
    else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
    else if (is_imm)     legal = 1'b1;
    else if (f3 == 3'd0) legal = (f7 == 7'h00) || (f7 == 7'h20);
    else                 legal = (f7 == 7'h00);
    case (f3)
      3'd0: begin
        if (!is_imm && f7 == 7'h20) s = longint'($signed(a)) - longint'($signed(b));
        else                        s = longint'($signed(a)) + longint'($signed(b));
        e.res = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: e.res = a << sh;
      3'd2: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: e.res = (a < b) ? 32'd1 : 32'd0;
      3'd4: e.res = a ^ b;
      3'd5: begin
        if (f7 == 7'h20) e.res = $signed(a) >>> sh;
        else             e.res = a >> sh;
      end
      3'd6: e.res = a | b;
      default: e.res = a & b;
    endcase
    if (!legal) begin
      e.res = 32'd0;
      e.ovf = 1'b0;
      e.ill = 1'b1;
    end
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Per-cycle compare against the model, then predict the coming clock edge.
  always @(negedge clk) begin
    logic exp_vis, exp_rdy, out_x;
    exp_t e;
    if (!rst) begin
      check("rst_out_valid", out_valid, 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_misc", {out_rd, out_overflow, out_zero, out_illegal}, 32'd0);
      check("rst_retired", retired, 32'd0);
      q.delete();
      ret_m      = 0;
      prev_stall = 1'b0;
    end else begin
      exp_vis = (q.size() > 0) && (q[0].push < edge_cnt);
      exp_rdy = !((q.size() == 2) && !out_ready);
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, exp_vis);
      check("retired", retired, ret_m);
      if (exp_vis) begin
        check("result", out_result, q[0].res);
        check("rd", out_rd, q[0].rd);
        check("flags", {out_overflow, out_zero, out_illegal}, {q[0].ovf, q[0].zero, q[0].ill});
      end
      if (prev_stall) check("stall_stable", {out_rd, out_result}, {prev_rd, prev_res});
      prev_stall = exp_vis && !out_ready && !flush;
      prev_res   = out_result;
      prev_rd    = out_rd;
      edge_cnt++;
      out_x = exp_vis && out_ready;
      if (out_x) begin
        void'(q.pop_front());
        if (ret_m < 32'd65535) ret_m++;
      end
      if (flush) q.delete();
      else if (in_valid && exp_rdy) begin
        e      = ref_op(in_funct3, in_funct7, in_is_imm, in_rs1, in_rs2, in_imm, in_rd);
        e.push = edge_cnt;
        q.push_back(e);
      end
    end
  end

  task automatic set_beat(input logic [2:0] f3, input logic [6:0] f7, input logic is_imm,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                          input logic [4:0] rd);
    in_valid  = 1'b1;
    in_funct3 = f3;
    in_funct7 = f7;
    in_is_imm = is_imm;
    in_rs1    = a;
    in_rs2    = b;
    in_imm    = imm;
    in_rd     = rd;
  endtask

  task automatic directed(input string name, input logic [2:0] f3, input logic [6:0] f7,
                          input logic is_imm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [31:0] res,
                          input logic ovf, input logic zero, input logic ill);
    int n;
    @(posedge clk); #1;
    set_beat(f3, f7, is_imm, a, b, imm, 5'd7);
    out_ready = 1'b1;
    flush     = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    check({name, "_latency"}, n, 32'd2);
    check({name, "_result"}, out_result, res);
    check({name, "_flags"}, {out_overflow, out_zero, out_illegal}, {ovf, zero, ill});
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
  endtask

  task automatic stall_test();
    int   idx, got;
    logic acc, saw_low;
    in_valid = 1'b0;
    pulse_reset();
    idx = 0; got = 0; acc = 1'b0; saw_low = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      if (acc) idx++;
      out_ready = !(cyc >= 2 && cyc <= 4);
      flush     = 1'b0;
      if (idx < 4) set_beat(3'd0, 7'h00, 1'b0, 32'd100, 32'(idx + 1), 32'd0, 5'(idx + 1));
      else in_valid = 1'b0;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) saw_low = 1'b1;
      if (out_valid && out_ready) begin
        check("stall_order", out_result, 32'd101 + 32'(got));
        got++;
      end
    end
    check("stall_in_ready_drop", saw_low, 32'd1);
    check("stall_count", got, 32'd4);
    check("stall_retired", retired, 32'd4);
  endtask

  task automatic flush_test();
    int cnt;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      set_beat(3'd6, 7'h00, 1'b1, 32'h10, 32'd0, 32'(i), 5'(i + 3));
      out_ready = 1'b0;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_both_full", in_ready, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", out_valid, 32'd0);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("flush_no_emit", cnt, 32'd0);
  endtask

  task automatic rand_cycle();
    logic [31:0] corner [5];
    corner[0] = 32'd0;          corner[1] = 32'h80000000; corner[2] = 32'h7FFFFFFF;
    corner[3] = 32'hFFFFFFFF;   corner[4] = $urandom;
    @(posedge clk); #1;
    in_valid  = ($urandom % 10) < 7;
    in_funct3 = 3'($urandom);
    case ($urandom % 8)
      0, 1, 2, 3: in_funct7 = 7'h00;
      4, 5:       in_funct7 = 7'h20;
      default:    in_funct7 = 7'($urandom);
    endcase
    in_is_imm = 1'($urandom);
    in_rs1    = (($urandom % 3) == 0) ? corner[$urandom % 5] : $urandom;
    in_rs2    = (($urandom % 3) == 0) ? corner[$urandom % 5] : $urandom;
    in_imm    = (($urandom % 3) == 0) ? corner[$urandom % 5] : $urandom;
    in_rd     = 5'($urandom);
    out_ready = ($urandom % 10) < 7;
    flush     = ($urandom % 40) == 0;
  endtask

  initial begin
    exp_t e;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_is_imm = 1'b0;
    in_rs1 = 32'd0; in_rs2 = 32'd0; in_imm = 32'd0; in_rd = 5'd0;
    #23 rst = 1'b1;

    e = ref_op(3'd0, 7'h20, 1'b0, 32'd5, 32'd3, 32'd0, 5'd1);
    check("model_sub", e.res, 32'd2);
    e = ref_op(3'd5, 7'h20, 1'b1, 32'h80000000, 32'd0, 32'd4, 5'd1);
    check("model_srai", e.res, 32'hF8000000);
    e = ref_op(3'd0, 7'h00, 1'b0, 32'h7FFFFFFF, 32'd1, 32'd0, 5'd1);
    check("model_add_ovf", {e.res, e.ovf}, {32'h80000000, 1'b1});

    directed("add",   3'd0, 7'h00, 1'b0, 32'd5,        32'd7, 32'd0,          32'd12,        1'b0, 1'b0, 1'b0);
    directed("sub",   3'd0, 7'h20, 1'b0, 32'h80000000, 32'd1, 32'd0,          32'h7FFFFFFF,  1'b1, 1'b0, 1'b0);
    directed("addi",  3'd0, 7'h00, 1'b1, 32'd3,        32'd0, 32'hFFFFFFFD,   32'd0,         1'b0, 1'b1, 1'b0);
    directed("addi7", 3'd0, 7'h20, 1'b1, 32'd10,       32'd0, 32'd5,          32'd15,        1'b0, 1'b0, 1'b0);
    directed("srli",  3'd5, 7'h00, 1'b1, 32'hF0000000, 32'd0, 32'h00000404,   32'h0F000000,  1'b0, 1'b0, 1'b0);
    directed("srai",  3'd5, 7'h20, 1'b1, 32'hF0000000, 32'd0, 32'h00000404,   32'hFF000000,  1'b0, 1'b0, 1'b0);
    directed("xorbad",3'd4, 7'h01, 1'b0, 32'h1234,     32'h1, 32'd0,          32'd0,         1'b0, 1'b1, 1'b1);
    directed("sllibad",3'd1,7'h20, 1'b1, 32'd1,        32'd0, 32'd3,          32'd0,         1'b0, 1'b1, 1'b1);
    directed("slt",   3'd2, 7'h00, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0,          32'd1,         1'b0, 1'b0, 1'b0);
    directed("sltu",  3'd3, 7'h00, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0,          32'd0,         1'b0, 1'b1, 1'b0);

    stall_test();
    flush_test();

    repeat (8) rand_cycle();
    @(posedge clk); #3 rst = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 32'd0);
    check("arst_out_data", {out_result, out_rd, out_overflow, out_zero, out_illegal}, 32'd0);
    check("arst_retired", retired, 32'd0);
    @(posedge clk); #3 rst = 1'b1;

    repeat (3000) rand_cycle();
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
